// File: rtl/sram_mem_dp_init.sv
// sram_mem_dp_init: true dual-port byte-enabled SRAM with self-clearing init sequencer and optional output register
module sram_mem_dp_init #(
  parameter int DWIDTH = 72,
  parameter int AWIDTH = 8,
  parameter int DEPTH = 2 ** AWIDTH,
  parameter int BWIDTH = DWIDTH / 8,
  parameter bit RD_MODE = 1'b0,
  parameter bit OUT_REG = 1'b0,
  parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  input  logic              ena,
  input  logic [BWIDTH-1:0] wea,
  input  logic [AWIDTH-1:0] addra,
  input  logic [DWIDTH-1:0] dina,
  output logic [DWIDTH-1:0] douta,
  output logic              douta_valid,
  input  logic              enb,
  input  logic [BWIDTH-1:0] web,
  input  logic [AWIDTH-1:0] addrb,
  input  logic [DWIDTH-1:0] dinb,
  output logic [DWIDTH-1:0] doutb,
  output logic              doutb_valid,
  output logic              collision
);
  typedef enum logic {CLEAR, READY} state_t;
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);
  state_t state, state_nx;
  logic [AWIDTH-1:0] ptr, ptr_nx;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic act, ina, inb, wra, wrb, same;
  logic [DWIDTH-1:0] olda, oldb, newa, newb, d1a, d1b, d2a, d2b;
  logic v1a, v1b, v2a, v2b;
  assign act = state == READY && !rst;
  assign ina = 32'(addra) < DEPTH;
  assign inb = 32'(addrb) < DEPTH;
  assign wra = act && ena && ina;
  assign wrb = act && enb && inb;
  assign same = addra == addrb;
  assign init_busy = rst || state == CLEAR;
  always_comb begin
    state_nx = state == CLEAR && ptr == LAST ? READY : state;
    ptr_nx = state == CLEAR ? ptr + 1'b1 : ptr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr <= '0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR) mem[ptr] <= INIT_VAL;
    else
      for (int i = 0; i < BWIDTH; i++) begin
        if (wrb && web[i]) mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
        if (wra && wea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
      end
  end
  always_comb begin
    olda = ina ? mem[addra] : '0;
    oldb = inb ? mem[addrb] : '0;
    newa = olda;
    newb = oldb;
    for (int i = 0; i < BWIDTH; i++) begin
      if (wrb && web[i] && same) newa[8*i +: 8] = dinb[8*i +: 8];
      if (wra && wea[i]) newa[8*i +: 8] = dina[8*i +: 8];
      if (wrb && web[i]) newb[8*i +: 8] = dinb[8*i +: 8];
      if (wra && wea[i] && same) newb[8*i +: 8] = dina[8*i +: 8];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1a <= 1'b0;
      v1b <= 1'b0;
      v2a <= 1'b0;
      v2b <= 1'b0;
      d1a <= '0;
      d1b <= '0;
      d2a <= '0;
      d2b <= '0;
      collision <= 1'b0;
    end else begin
      v1a <= act && ena;
      v1b <= act && enb;
      if (act && ena) d1a <= RD_MODE ? newa : olda;
      if (act && enb) d1b <= RD_MODE ? newb : oldb;
      v2a <= v1a;
      v2b <= v1b;
      if (v1a) d2a <= d1a;
      if (v1b) d2b <= d1b;
      collision <= wra && wrb && same && |wea && |web;
    end
  end
  assign douta = OUT_REG ? d2a : d1a;
  assign doutb = OUT_REG ? d2b : d1b;
  assign douta_valid = OUT_REG ? v2a : v1a;
  assign doutb_valid = OUT_REG ? v2b : v1b;
endmodule

// File: tb/tb_sram_mem_dp_init.sv
// tb_sram_mem_dp_init: scoreboard bench for two sram_mem_dp_init configurations
module tb_sram_mem_dp_init;
  localparam logic [71:0] IV1 = {9{8'hA5}};
  localparam logic [71:0] ONES = {72{1'b1}};
  typedef struct {int d; int p; logic [71:0] v; int c;} ent_t;
  logic clk = 1'b0, rst = 1'b1;
  logic en [2][2];
  logic [8:0] we [2][2];
  logic [7:0] ad [2][2];
  logic [71:0] di [2][2];
  logic [71:0] dout [2][2];
  logic dv [2][2];
  logic col [2], busy [2];
  logic [71:0] m [2][256];
  ent_t sb [$];
  int cyc = 0, n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  sram_mem_dp_init u0 (
    .clk(clk), .rst(rst), .init_busy(busy[0]),
    .ena(en[0][0]), .wea(we[0][0]), .addra(ad[0][0]), .dina(di[0][0]), .douta(dout[0][0]), .douta_valid(dv[0][0]),
    .enb(en[0][1]), .web(we[0][1]), .addrb(ad[0][1]), .dinb(di[0][1]), .doutb(dout[0][1]), .doutb_valid(dv[0][1]),
    .collision(col[0]));
  sram_mem_dp_init #(.DEPTH(200), .RD_MODE(1'b1), .OUT_REG(1'b1), .INIT_VAL(IV1)) u1 (
    .clk(clk), .rst(rst), .init_busy(busy[1]),
    .ena(en[1][0]), .wea(we[1][0]), .addra(ad[1][0]), .dina(di[1][0]), .douta(dout[1][0]), .douta_valid(dv[1][0]),
    .enb(en[1][1]), .web(we[1][1]), .addrb(ad[1][1]), .dinb(di[1][1]), .doutb(dout[1][1]), .doutb_valid(dv[1][1]),
    .collision(col[1]));
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        if (dv[d][p]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].d == d && sb[i].p == p) idx = i;
          n_chk++;
          if (idx < 0) $display("FAIL unexpected_valid dut%0d port%0d: got data %h with no pending read", d, p, dout[d][p]);
          else begin
            if (dout[d][p] !== sb[idx].v || cyc != sb[idx].c)
              $display("FAIL read dut%0d port%0d: got %h at cycle %0d, want %h at cycle %0d", d, p, dout[d][p], cyc, sb[idx].v, sb[idx].c);
            else n_pass++;
            sb.delete(idx);
          end
        end
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].c < cyc) begin
        n_chk++;
        $display("FAIL missing_valid dut%0d port%0d: got no valid by cycle %0d, want %h", sb[i].d, sb[i].p, cyc, sb[i].v);
        sb.delete(i);
      end
  end
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
  task automatic acc(input int d, input logic ea, input logic [8:0] wa, input logic [7:0] aa, input logic [71:0] da,
                     input logic eb, input logic [8:0] wb, input logic [7:0] ab, input logic [71:0] db);
    int dp;
    logic [71:0] oa, ob, na, nb;
    dp = d ? 200 : 256;
    en[1-d][0] = 1'b0;
    en[1-d][1] = 1'b0;
    en[d][0] = ea; we[d][0] = wa; ad[d][0] = aa; di[d][0] = da;
    en[d][1] = eb; we[d][1] = wb; ad[d][1] = ab; di[d][1] = db;
    oa = 32'(aa) < dp ? m[d][aa] : '0;
    ob = 32'(ab) < dp ? m[d][ab] : '0;
    for (int i = 0; i < 9; i++) begin
      if (eb && wb[i] && 32'(ab) < dp) m[d][ab][8*i +: 8] = db[8*i +: 8];
      if (ea && wa[i] && 32'(aa) < dp) m[d][aa][8*i +: 8] = da[8*i +: 8];
    end
    na = 32'(aa) < dp ? m[d][aa] : '0;
    nb = 32'(ab) < dp ? m[d][ab] : '0;
    if (ea) sb.push_back('{d, 0, d ? na : oa, cyc + 1 + d});
    if (eb) sb.push_back('{d, 1, d ? nb : ob, cyc + 1 + d});
    @(negedge clk);
    en[d][0] = 1'b0;
    en[d][1] = 1'b0;
  endtask
  task automatic run_init(output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 256; i++) begin
      m[0][i] = '0;
      m[1][i] = IV1;
    end
    rst = 1'b0;
    for (int c = 0; c < 320; c++) begin
      if (busy[0]) n0++;
      if (busy[1]) n1++;
      en[0][0] = c < 100 || (busy[0] && n0 == 256);
      we[0][0] = c < 100 ? 9'h1FF : 9'h000;
      ad[0][0] = 8'(c);
      di[0][0] = ONES;
      en[1][0] = busy[1] && n1 == 200;
      we[1][0] = 9'h000;
      ad[1][0] = 8'd0;
      @(negedge clk);
    end
    en[0][0] = 1'b0;
    en[1][0] = 1'b0;
  endtask
  task automatic test_reset;
    int n0, n1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (busy[d] !== 1'b1 || dout[d][0] !== '0 || dout[d][1] !== '0 || dv[d][0] !== 1'b0 || dv[d][1] !== 1'b0 || col[d] !== 1'b0)
        $display("FAIL reset_state dut%0d: got busy=%b douta=%h doutb=%h va=%b vb=%b col=%b, want busy=1 and all else 0",
                 d, busy[d], dout[d][0], dout[d][1], dv[d][0], dv[d][1], col[d]);
      else n_pass++;
    end
    run_init(n0, n1);
    n_chk++;
    if (n0 != 256) $display("FAIL init_len dut0: got %0d busy cycles, want 256", n0); else n_pass++;
    n_chk++;
    if (n1 != 200) $display("FAIL init_len dut1: got %0d busy cycles, want 200", n1); else n_pass++;
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 256; a++) acc(d, 1'b1, 9'h0, 8'(a), '0, 1'b1, 9'h0, 8'(255 - a), '0);
    repeat (3) @(negedge clk);
  endtask
  task automatic test_byte_en;
    for (int d = 0; d < 2; d++) begin
      acc(d, 1'b1, 9'h1FF, 8'd5, ONES, 1'b0, 9'h0, 8'd0, '0);
      acc(d, 1'b1, 9'h001, 8'd5, '0, 1'b0, 9'h0, 8'd0, '0);
      acc(d, 1'b1, 9'h000, 8'd5, '0, 1'b0, 9'h0, 8'd0, '0);
      acc(d, 1'b0, 9'h000, 8'd0, '0, 1'b1, 9'h100, 8'd5, 72'h77_0000_0000_0000_0000);
      acc(d, 1'b0, 9'h000, 8'd0, '0, 1'b1, 9'h000, 8'd5, '0);
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic test_rdw;
    for (int d = 0; d < 2; d++) begin
      acc(d, 1'b1, 9'h1FF, 8'd3, 72'h11, 1'b0, 9'h0, 8'd0, '0);
      acc(d, 1'b1, 9'h1FF, 8'd3, 72'h22, 1'b1, 9'h0, 8'd3, '0);
      acc(d, 1'b1, 9'h000, 8'd3, '0, 1'b1, 9'h002, 8'd3, 72'h3300);
      acc(d, 1'b1, 9'h000, 8'd3, '0, 1'b0, 9'h0, 8'd0, '0);
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic test_dual_write;
    for (int d = 0; d < 2; d++) begin
      acc(d, 1'b1, 9'h1FF, 8'd7, 72'hAA, 1'b1, 9'h1FF, 8'd7, 72'hBB);
      n_chk++;
      if (col[d] !== 1'b1) $display("FAIL collision_full dut%0d: got %b, want 1", d, col[d]); else n_pass++;
      @(negedge clk);
      n_chk++;
      if (col[d] !== 1'b0) $display("FAIL collision_pulse dut%0d: got %b, want 0", d, col[d]); else n_pass++;
      acc(d, 1'b1, 9'h000, 8'd7, '0, 1'b1, 9'h000, 8'd7, '0);
      n_chk++;
      if (col[d] !== 1'b0) $display("FAIL collision_reads dut%0d: got %b, want 0", d, col[d]); else n_pass++;
      acc(d, 1'b1, 9'h001, 8'd7, 72'hCC, 1'b1, 9'h1FE, 8'd7, {9{8'hDD}});
      n_chk++;
      if (col[d] !== 1'b1) $display("FAIL collision_disjoint dut%0d: got %b, want 1", d, col[d]); else n_pass++;
      acc(d, 1'b1, 9'h1FF, 8'd8, 72'h88, 1'b1, 9'h1FF, 8'd9, 72'h99);
      n_chk++;
      if (col[d] !== 1'b0) $display("FAIL collision_diff_addr dut%0d: got %b, want 0", d, col[d]); else n_pass++;
      acc(d, 1'b1, 9'h000, 8'd7, '0, 1'b1, 9'h000, 8'd8, '0);
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic test_pipeline;
    for (int a = 0; a < 3; a++) acc(1, 1'b1, 9'h1FF, 8'(a), 72'h100 + 72'(a), 1'b0, 9'h0, 8'd0, '0);
    repeat (3) @(negedge clk);
    acc(1, 1'b1, 9'h0, 8'd0, '0, 1'b0, 9'h0, 8'd0, '0);
    n_chk++;
    if (dv[1][0] !== 1'b0) $display("FAIL pipe_lat2_early: got valid %b, want 0", dv[1][0]); else n_pass++;
    acc(1, 1'b1, 9'h0, 8'd1, '0, 1'b0, 9'h0, 8'd0, '0);
    n_chk++;
    if (dv[1][0] !== 1'b1 || dout[1][0] !== 72'h100) $display("FAIL pipe_beat0: got %b/%h, want 1/100", dv[1][0], dout[1][0]); else n_pass++;
    acc(1, 1'b1, 9'h0, 8'd2, '0, 1'b0, 9'h0, 8'd0, '0);
    n_chk++;
    if (dv[1][0] !== 1'b1 || dout[1][0] !== 72'h101) $display("FAIL pipe_beat1: got %b/%h, want 1/101", dv[1][0], dout[1][0]); else n_pass++;
    @(negedge clk);
    n_chk++;
    if (dv[1][0] !== 1'b1 || dout[1][0] !== 72'h102) $display("FAIL pipe_beat2: got %b/%h, want 1/102", dv[1][0], dout[1][0]); else n_pass++;
    @(negedge clk);
    n_chk++;
    if (dv[1][0] !== 1'b0 || dout[1][0] !== 72'h102) $display("FAIL pipe_hold: got %b/%h, want 0/102", dv[1][0], dout[1][0]); else n_pass++;
    acc(0, 1'b1, 9'h1FF, 8'd4, 72'h44, 1'b0, 9'h0, 8'd0, '0);
    n_chk++;
    if (dv[0][0] !== 1'b1 || dout[0][0] !== 72'h0) $display("FAIL lat1_read_first: got %b/%h, want 1/0", dv[0][0], dout[0][0]); else n_pass++;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_back_to_back;
    for (int k = 0; k < 80; k++) begin
      logic [7:0] aa, ab;
      aa = $urandom_range(0, 3) == 0 ? 8'($urandom_range(190, 235)) : 8'($urandom_range(0, 15));
      ab = $urandom_range(0, 3) == 0 ? 8'($urandom_range(190, 235)) : 8'($urandom_range(0, 15));
      acc(k % 2, 1'($urandom), $urandom_range(0, 1) ? 9'($urandom) : 9'h0, aa, 72'({$urandom(), $urandom(), $urandom()}),
          1'($urandom), $urandom_range(0, 1) ? 9'($urandom) : 9'h0, ab, 72'({$urandom(), $urandom(), $urandom()}));
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic test_mid_reset;
    int n0, n1;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (dout[0][0] !== '0 || dout[1][0] !== '0 || busy[0] !== 1'b1)
      $display("FAIL ready_reset: got dout0=%h dout1=%h busy=%b, want 0/0/1", dout[0][0], dout[1][0], busy[0]);
    else n_pass++;
    rst = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy[1] !== 1'b1) $display("FAIL midinit_busy: got %b, want 1", busy[1]); else n_pass++;
    run_init(n0, n1);
    n_chk++;
    if (n0 != 256) $display("FAIL reinit_len dut0: got %0d busy cycles, want 256", n0); else n_pass++;
    n_chk++;
    if (n1 != 200) $display("FAIL reinit_len dut1: got %0d busy cycles, want 200", n1); else n_pass++;
    for (int d = 0; d < 2; d++) begin
      acc(d, 1'b1, 9'h1FF, 8'd220, ONES, 1'b0, 9'h0, 8'd0, '0);
      acc(d, 1'b1, 9'h000, 8'd220, '0, 1'b1, 9'h000, 8'd20, '0);
      acc(d, 1'b1, 9'h1FF, 8'd199, 72'h199, 1'b1, 9'h000, 8'd100, '0);
      acc(d, 1'b1, 9'h000, 8'd199, '0, 1'b1, 9'h000, 8'd255, '0);
    end
    repeat (3) @(negedge clk);
  endtask
  initial begin
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        en[d][p] = 1'b0; we[d][p] = '0; ad[d][p] = '0; di[d][p] = '0;
      end
    @(negedge clk);
    test_reset;
    test_byte_en;
    test_rdw;
    test_dual_write;
    test_pipeline;
    test_back_to_back;
    test_mid_reset;
    n_chk++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
